// File: rtl/signed_mult_seq_if.sv
// signed_mult_seq_if
// Bundles the handshake and data signals of the sequential multiplier so
// that producer and multiplier share one port list.
//   i_enable      : global clock-enable, low freezes every register in the unit
//   i_start       : operation request, sampled only while the unit is idle
//   i_signed_mode : 1 = operands are two's complement, 0 = unsigned
//   i_a, i_b      : W-bit multiplicand / multiplier, latched on acceptance
//   o_busy        : high while an operation is in flight
//   o_done        : one-cycle pulse when a new product is on o_q
//   o_q           : 2W-bit product, held until the next o_done
// Modports: master drives the requests (producer side), slave is the multiplier.
interface signed_mult_seq_if #(
  parameter int W = 8
);
  logic           i_enable;
  logic           i_start;
  logic           i_signed_mode;
  logic [W-1:0]   i_a;
  logic [W-1:0]   i_b;
  logic           o_busy;
  logic           o_done;
  logic [2*W-1:0] o_q;

  modport master (
    output i_enable, i_start, i_signed_mode, i_a, i_b,
    input  o_busy, o_done, o_q
  );

  modport slave (
    input  i_enable, i_start, i_signed_mode, i_a, i_b,
    output o_busy, o_done, o_q
  );
endinterface

// File: rtl/signed_mult_seq.sv
// signed_mult_seq
// W x W sequential shift-add multiplier with a start/done handshake and a
// run-time signed/unsigned mode. Operands are converted to magnitudes on
// acceptance, multiplied unsigned over exactly W enabled cycles with a single
// 2W-bit adder, and the sign is applied in a final fix-up cycle.
// Latency: start accepted at edge E0, product and done visible after E(W+1).
// Ports:
//   i_clk : system clock, rising-edge active
//   i_rst : asynchronous active-high reset, aborts any operation in flight
//   bus   : signed_mult_seq_if slave modport (enable, start, mode, a, b,
//           busy, done, q)
module signed_mult_seq #(
  parameter int W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  signed_mult_seq_if.slave bus
);

  localparam int CW = $clog2(W);
  localparam int PW = 2 * W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_ma;
  logic [W-1:0]    r_mb;
  logic            r_neg;
  logic [PW-1:0]   r_acc;
  logic [PW-1:0]   r_q;
  logic            r_done;

  logic [PW-1:0]   w_addend;
  logic [W-1:0]    w_mag_a;
  logic [W-1:0]    w_mag_b;
  logic            w_last;

  // Magnitude of the most negative value is 2^(W-1), which still fits in W
  // unsigned bits, so the plain two's complement negate never overflows here.
  assign w_mag_a = (bus.i_signed_mode && bus.i_a[W-1]) ? (~bus.i_a + W'(1)) : bus.i_a;
  assign w_mag_b = (bus.i_signed_mode && bus.i_b[W-1]) ? (~bus.i_b + W'(1)) : bus.i_b;

  // Partial product for the current multiplier bit, aligned to its weight.
  assign w_addend = {{W{1'b0}}, r_ma} << r_cnt;
  assign w_last   = (r_cnt == CW'(W - 1));

  assign bus.o_busy = (r_state != S_IDLE);
  assign bus.o_done = r_done;
  assign bus.o_q    = r_q;

  // Whole controller and datapath in one block; enable low freezes all of it,
  // including a pending done pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ma    <= '0;
      r_mb    <= '0;
      r_neg   <= 1'b0;
      r_acc   <= '0;
      r_q     <= '0;
      r_done  <= 1'b0;
    end else if (bus.i_enable) begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_ma    <= w_mag_a;
            r_mb    <= w_mag_b;
            r_neg   <= bus.i_signed_mode & (bus.i_a[W-1] ^ bus.i_b[W-1]);
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        // Fixed W iterations, no early exit, so latency is data independent.
        S_RUN: begin
          if (r_mb[r_cnt]) begin
            r_acc <= r_acc + w_addend;
          end
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        // A zero magnitude negates to zero, so neg needs no special case.
        S_FIX: begin
          r_q     <= r_neg ? (~r_acc + PW'(1)) : r_acc;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
